// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch FSM states and the opcode
// constants used by both the fetch unit and the main control decoder.
package cpu_pkg;

    localparam int OPCODE_W = 6;
    localparam int INSTR_W  = 32;
    localparam int PC_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPCODE_W];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small prefetch FIFO of {pc, instr} pairs; flush empties it and overrides
// any push or pop requested in the same cycle.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [PC_W-1:0]    push_pc_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    output logic [PC_W-1:0]    head_pc_o,
    output logic [INSTR_W-1:0] head_instr_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = PC_W + INSTR_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage is reset so the head outputs read as zero straight out of reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (!flush_i && do_push && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= {push_pc_i, push_instr_i};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_pc_o    = mem_q[rd_ptr_q][ENT_W-1 -: PC_W];
    assign head_instr_o = mem_q[rd_ptr_q][INSTR_W-1:0];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding instruction-memory read, a prefetch
// queue toward decode, and redirect handling that discards stale responses.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0040_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [OPCODE_W-1:0] if_opcode,
    output logic [PC_W-1:0]     if_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] q_count, count_next;
    logic             q_full, q_empty;
    logic             push, pop;

    assign pop        = if_valid && if_ready;
    assign count_next = q_count + CNT_W'(1) - CNT_W'(pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect)     fetch_pc_d = redirect_pc;
                else if (!q_full) state_d    = WAIT;
            end
            WAIT: begin
                if (redirect) begin
                    // A response arriving with the redirect is stale; without
                    // one, the request is still in flight and must be dropped.
                    fetch_pc_d = redirect_pc;
                    state_d    = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_W'(4);
                    state_d    = (count_next < CNT_W'(DEPTH)) ? WAIT : IDLE;
                end
            end
            DROP: begin
                if (redirect) fetch_pc_d = redirect_pc;
                if (imem_ack) state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= PC_RESET;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (redirect),
        .push_pc_i    (fetch_pc_q),
        .push_instr_i (imem_rdata),
        .head_pc_o    (if_pc),
        .head_instr_o (if_instr),
        .count_o      (q_count),
        .full_o       (q_full),
        .empty_o      (q_empty)
    );

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = fetch_pc_q;
    assign if_valid  = !q_empty;
    assign if_opcode = opcode_of(if_instr);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: zero-wait streaming, backpressure, redirects
// with late and same-cycle responses, opcode extraction and async reset.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [5:0]  if_opcode;
    logic [31:0] if_pc;

    // Memory model: zero-wait mode acks in the same cycle and returns ~addr.
    logic        zw;
    logic        ack_man;
    logic [31:0] rdata_man;

    int n_checks = 0;
    int n_fail   = 0;

    assign imem_ack   = zw ? imem_req : ack_man;
    assign imem_rdata = zw ? ~imem_addr : rdata_man;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_opcode   (if_opcode),
        .if_pc       (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; zw = 1'b1; ack_man = 1'b0; rdata_man = '0;
        redirect = 1'b0; redirect_pc = '0; if_ready = 1'b1;

        // Reset values, then zero-wait streaming at one instruction per cycle
        tick();
        check("rst_req",    32'(imem_req),  32'd0);
        check("rst_addr",   imem_addr,      32'h0040_0000);
        check("rst_valid",  32'(if_valid),  32'd0);
        check("rst_instr",  if_instr,       32'h0);
        check("rst_opcode", 32'(if_opcode), 32'h0);
        check("rst_pc",     if_pc,          32'h0);
        rst = 1'b0;
        tick();
        check("s1_req0",   32'(imem_req), 32'd1);
        check("s1_addr0",  imem_addr,     32'h0040_0000);
        check("s1_valid0", 32'(if_valid), 32'd0);
        tick();
        check("s1_valid1", 32'(if_valid), 32'd1);
        check("s1_pc1",    if_pc,         32'h0040_0000);
        check("s1_instr1", if_instr,      32'hFFBF_FFFF);
        check("s1_addr1",  imem_addr,     32'h0040_0004);
        tick();
        check("s1_pc2",    if_pc,         32'h0040_0004);
        check("s1_instr2", if_instr,      32'hFFBF_FFFB);
        check("s1_addr2",  imem_addr,     32'h0040_0008);
        tick();
        check("s1_pc3",    if_pc,         32'h0040_0008);
        check("s1_addr3",  imem_addr,     32'h0040_000C);

        // Backpressure: queue fills after two pushes, then drains in order
        if_ready = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        check("s2_req_full",  32'(imem_req), 32'd0);
        check("s2_addr_full", imem_addr,     32'h0040_0008);
        check("s2_head0",     if_pc,         32'h0040_0000);
        tick();
        check("s2_req_hold",  32'(imem_req), 32'd0);
        if_ready = 1'b1;
        tick();
        check("s2_head1",     if_pc,         32'h0040_0004);
        check("s2_req_pop1",  32'(imem_req), 32'd0);
        tick();
        check("s2_valid_pop2", 32'(if_valid), 32'd0);
        check("s2_req_resume", 32'(imem_req), 32'd1);
        check("s2_addr_resume", imem_addr,    32'h0040_0008);
        tick();
        check("s2_head2",     if_pc,         32'h0040_0008);

        // Slow memory: redirect while a request is in flight, late ack dropped
        zw = 1'b0;
        do_reset();
        tick();
        check("s3_req",   32'(imem_req), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        check("s3_drop_req",   32'(imem_req), 32'd1);
        check("s3_drop_addr",  imem_addr,     32'h0000_0100);
        check("s3_drop_valid", 32'(if_valid), 32'd0);
        tick();
        ack_man = 1'b1; rdata_man = 32'hDEAD_BEEF;
        tick();
        ack_man = 1'b0;
        check("s3_idle_req",   32'(imem_req), 32'd0);
        check("s3_idle_valid", 32'(if_valid), 32'd0);
        tick();
        check("s3_new_req",   32'(imem_req), 32'd1);
        check("s3_new_addr",  imem_addr,     32'h0000_0100);
        check("s3_new_valid", 32'(if_valid), 32'd0);

        // Redirect coinciding with ack and pop: flush, no push, fetch_pc moves
        zw = 1'b1; if_ready = 1'b1;
        do_reset();
        tick();
        tick();
        check("s4_valid_pre", 32'(if_valid), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_2000;
        tick();
        redirect = 1'b0;
        check("s4_valid",  32'(if_valid), 32'd0);
        check("s4_req",    32'(imem_req), 32'd0);
        check("s4_addr",   imem_addr,     32'h0000_2000);
        tick();
        check("s4_req2",   32'(imem_req), 32'd1);
        check("s4_valid2", 32'(if_valid), 32'd0);
        tick();
        check("s4_pc3",    if_pc,         32'h0000_2000);
        check("s4_instr3", if_instr,      32'hFFFF_DFFF);

        // Opcode field extraction on real MIPS words
        zw = 1'b0; if_ready = 1'b0; ack_man = 1'b0;
        do_reset();
        tick();
        ack_man = 1'b1; rdata_man = 32'h8C43_0004;
        tick();
        ack_man = 1'b0;
        check("s5_lw_opcode", 32'(if_opcode), 32'h23);
        check("s5_lw_instr",  if_instr,       32'h8C43_0004);
        check("s5_lw_pc",     if_pc,          32'h0040_0000);
        ack_man = 1'b1; rdata_man = 32'h0800_0040; if_ready = 1'b1;
        tick();
        ack_man = 1'b0; if_ready = 1'b0;
        check("s5_j_opcode",  32'(if_opcode), 32'h02);
        check("s5_j_instr",   if_instr,       32'h0800_0040);
        check("s5_j_pc",      if_pc,          32'h0040_0004);

        // Async reset while in WAIT, then an ack in IDLE must be ignored
        check("s6_pre_req",   32'(imem_req), 32'd1);
        check("s6_pre_valid", 32'(if_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("s6_req",    32'(imem_req),  32'd0);
        check("s6_addr",   imem_addr,      32'h0040_0000);
        check("s6_valid",  32'(if_valid),  32'd0);
        check("s6_instr",  if_instr,       32'h0);
        check("s6_opcode", 32'(if_opcode), 32'h0);
        check("s6_pc",     if_pc,          32'h0);
        tick();
        rst = 1'b0; ack_man = 1'b1; rdata_man = 32'h1234_5678;
        tick();
        ack_man = 1'b0;
        check("s6_ign_valid", 32'(if_valid), 32'd0);
        check("s6_ign_instr", if_instr,      32'h0);
        check("s6_ign_req",   32'(imem_req), 32'd1);
        check("s6_ign_addr",  imem_addr,     32'h0040_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the single-issue MIPS core; it is the producer of the instruction word whose opcode field the main control decoder consumes. It keeps the fetch PC and issues word reads to instruction memory, with one request outstanding at a time. Returned words go into a small prefetch queue, which is presented to decode with a valid/ready handshake. Jump and taken-branch redirects flush the queue and discard any in-flight stale response.

## Interface
- PC_RESET, 32'h0040_0000, fetch PC after reset
- DEPTH, 2, prefetch queue entries (2..4)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  read request; held until imem_ack
- imem_addr  out  32  word address; stable while imem_req=1
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  32  instruction word
- redirect  in  1  jump/taken-branch redirect, single-cycle pulse
- redirect_pc  in  32  new fetch PC; word-aligned
- if_valid  out  1  queue head valid
- if_ready  in  1  decode accepts head
- if_instr  out  32  head instruction word
- if_opcode  out  6  if_instr[31:26]
- if_pc  out  32  PC of head instruction

## Operation
- State machine, states IDLE, WAIT and DROP:
  - IDLE has no request outstanding.
  - WAIT has a request outstanding whose data will be kept.
  - DROP has a request outstanding whose data will be discarded.
- imem_req = (state != IDLE).
- imem_addr = fetch_pc register.
- IDLE -> WAIT when count < DEPTH and !redirect.
- WAIT, imem_ack=1, !redirect:
  - push {fetch_pc, imem_rdata} into the queue.
  - fetch_pc += 4, wrapping mod 2^32.
  - next state is WAIT if count_next < DEPTH, else IDLE.
  - count_next = count + 1 − pop.
- WAIT, redirect=1 (with or without ack): no push; fetch_pc <= redirect_pc; queue flushed.
  - With ack in the same cycle: next state IDLE.
  - Without ack: next state DROP.
- DROP, imem_ack=1: data discarded; next state IDLE.
- redirect in DROP or IDLE: fetch_pc <= redirect_pc; queue flushed; state unchanged.
- Pop occurs when if_valid && if_ready. Redirect takes priority over pop and push in the same cycle, and the queue is empty next cycle.
- imem_ack in IDLE is ignored.
- Queue full: no new request is issued. Queue empty: if_valid=0.
- Order is strictly preserved.

## Timing
- Reset values:
  - state IDLE, count 0, fetch_pc PC_RESET.
  - imem_req 0, imem_addr PC_RESET.
  - if_valid 0; if_instr, if_opcode and if_pc all 0.
- First imem_req is high on the first edge after rst deasserts.
- imem_ack sampled at edge N: if_valid=1 and head data visible after edge N.
- Throughput with zero-wait memory (ack in the same cycle as req): 1 instruction/cycle, sustained while if_ready=1.
- Redirect at edge N: if_valid=0 after N.
  - If state was IDLE or the ack arrived that cycle, the first request to redirect_pc is issued after edge N+1.
- rst asserted mid-operation forces all reset values immediately. The memory side is reset by the same rst.
- Head outputs are registered and are not combinational from imem_rdata.

## Structure
- Shared package cpu_pkg holds:
  - OPCODE_W=6, INSTR_W=32, PC_W=32.
  - fetch_state_t enum {IDLE, WAIT, DROP}.
  - OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW opcode constants, shared with the control decoder.
- Sub-module fetch_queue: synchronous FIFO of {pc, instr}, parameter DEPTH, with push, pop, flush, count, full and empty.
  - flush overrides push and pop.
- instr_fetch itself contains only the FSM, fetch_pc and glue.

## Test plan
- Reset with PC_RESET=0x0040_0000, zero-wait memory, if_ready=1 -> imem_addr 0x00400000, 0x00400004, 0x00400008; if_pc follows one cycle behind; one instruction per cycle.
- if_ready=0, zero-wait memory -> after 2 pushes imem_req=0 and imem_addr=0x00400008. Raising if_ready -> the two entries pop in order, then fetch resumes at 0x00400008.
- 3-cycle memory latency, redirect to 0x0000_0100 one cycle after the request -> state DROP, the late ack is discarded, if_valid stays 0, next request imem_addr=0x00000100.
- Redirect in the same cycle as imem_ack and a pop with a 2-entry queue -> the queue is empty next cycle, no push occurs, fetch_pc=redirect_pc.
- Word 0x8C430004 returned -> if_opcode=6'b100011 and if_instr=0x8C430004. Word 0x08000040 -> if_opcode=6'b000010.
- rst asserted while in WAIT, then an ack pulse after release while in IDLE -> all outputs are at reset values and the ack is ignored.
